sram_mem_ctrl: RTL
==================

Name: sram_mem_ctrl

Overview:
- MEM-stage controller that consumes the EXE result: the ALU `res` for LDR/STR is the byte address, and the store value arrives alongside it.
- Executes each 32-bit access as two 16-bit transfers on an external asynchronous SRAM, with programmable wait states.
- Drops `ready` low to freeze the whole pipeline until the access completes.
- Returns load data to the MEM/WB register.

Parameters:
- WORD_WIDTH, 32 (from `WORD_WIDTH` in the shared constants): data and address width on the pipeline side.
- SRAM_AW, 18: SRAM halfword address width.
- ADDR_OFFSET, 1024: byte base of data memory, subtracted from the ALU address.
- WAIT_CYCLES, 1: extra cycles per halfword phase. Legal values are 1..15.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, synchronous, active-low.
- mem_r_en  in  1  LDR in MEM stage.
- mem_w_en  in  1  STR in MEM stage.
- alu_res  in  WORD_WIDTH  byte address from the ALU.
- st_val  in  WORD_WIDTH  store data.
- ready  out  1  1 = MEM stage may advance; 0 = freeze all pipeline registers.
- mem_rdata  out  WORD_WIDTH  load result.
- sram_addr  out  SRAM_AW  halfword address.
- sram_dq  inout  16  SRAM data bus.
- sram_we_n  out  1  write strobe, active-low.
- sram_oe_n  out  1  output enable, active-low.

Behaviour:
- States:
  - IDLE
  - LO: low halfword phase
  - HI: high halfword phase
  - DONE
- req = mem_r_en | mem_w_en. If both are set, the access is treated as a write.
- IDLE transitions:
  - req=1 → LO; latch is_wr, alu_res and st_val in the same edge.
  - req=0 → stay in IDLE.
- LO and HI phases:
  - Each phase lasts exactly WAIT_CYCLES+1 cycles, timed by a 4-bit phase counter cleared on entry.
  - LO → HI and HI → DONE on the last cycle of the phase.
- DONE → IDLE unconditionally. The next request starts from IDLE, so back-to-back accesses are never merged.
- ready = (state==DONE) | (state==IDLE & ~req).
  - For an access accepted in IDLE, ready is low for 1 + 2*(WAIT_CYCLES+1) cycles, then high for exactly one DONE cycle.
  - With WAIT_CYCLES=1 that is 5 low cycles, with DONE in cycle 6.
- Address:
  - word = (latched_addr − ADDR_OFFSET) >> 2, evaluated at WORD_WIDTH width with wrap-around.
  - sram_addr = {word[SRAM_AW-2:0], phase_bit}, where phase_bit is 0 in LO and 1 in HI.
  - addr[1:0] is ignored, so there is no misalignment trap.
  - Addresses below ADDR_OFFSET wrap modulo 2^SRAM_AW halfwords.
- Write:
  - sram_dq is driven with st_val[15:0] in LO and st_val[31:16] in HI, for the whole phase.
  - sram_we_n = 0 on every phase cycle except the last, which is kept high for hold.
  - sram_oe_n = 1 throughout.
- Read:
  - sram_dq is high-Z and sram_oe_n = 0 during LO/HI; sram_we_n = 1.
  - The halfword is sampled on the last cycle of each phase: into the low half after LO, into the high half after HI.
  - mem_rdata is updated only on entry to DONE and holds until the next read completes.
  - A write never changes mem_rdata.
- Outside LO/HI:
  - sram_dq is high-Z, sram_we_n = 1, sram_oe_n = 1.
  - sram_addr holds its last value (0 after reset).
- Input changes on req/addr/data after acceptance are ignored until IDLE.
- Reset (rst_n=0 at a clock edge), including mid-transaction:
  - state → IDLE and counter → 0.
  - mem_rdata → 0 and sram_addr → 0.
  - we_n = oe_n = 1 and dq high-Z on the following cycle.
  - The aborted write may leave SRAM partially written. This is accepted behaviour.
- The ALU and other upstream stages are frozen while ready=0. This block never observes the ALU changing mid-access.

Decomposition:
- Shared constants header:
  - WORD_WIDTH.
  - The state encodings (2-bit localparams IDLE=0, LO=1, HI=2, DONE=3).
  - ADDR_OFFSET default.
- One natural sub-module, sram_phase_timer: the 4-bit counter with a `last` output, reused for both phases.
- The FSM, datapath latches and tri-state driver stay in sram_mem_ctrl.

Test Plan:
1. Store: WAIT_CYCLES=1, mem_w_en=1, alu_res=1024, st_val=0xDEADBEEF.
   - sram_addr=0 with dq=0xBEEF, then sram_addr=1 with dq=0xDEAD.
   - we_n low for exactly 1 cycle per phase.
   - ready low for 5 cycles, then high for 1 cycle.
2. Load back: mem_r_en=1, alu_res=1024, SRAM model returns the stored halfwords.
   - mem_rdata=0xDEADBEEF in the DONE cycle.
   - oe_n low for 4 cycles; dq never driven by the DUT.
3. Back-to-back: STR to 1028 immediately followed by LDR from 1028.
   - Two separate IDLE→DONE sequences; second uses sram_addr 2/3.
   - Load returns the stored value.
4. Wait states: WAIT_CYCLES=3, load.
   - Each phase lasts 4 cycles; ready low for 9 cycles.
   - Sampling occurs only on the 4th cycle of each phase.
5. Reset mid-write: assert rst_n=0 during HI.
   - Next cycle: IDLE, ready=1 with req=0, we_n=oe_n=1, dq=Z, mem_rdata=0.
6. Idle, boundary and mixed cases:
   - No request → ready stays 1 and no SRAM strobes ever.
   - alu_res=1020 → word wraps, sram_addr=0x3FFFE/0x3FFFF.
   - mem_r_en & mem_w_en both set → executes as a write.

Source files
------------

// File: rtl/sram_mem_ctrl_pkg.sv
// Shared constants for the MEM-stage SRAM controller.
//   WORD_WIDTH      : pipeline data/address width
//   DEF_ADDR_OFFSET : default byte base of data memory
//   mem_state_e     : controller FSM states
package sram_mem_ctrl_pkg;

  localparam int unsigned WORD_WIDTH      = 32;
  localparam int unsigned DEF_ADDR_OFFSET = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/sram_phase_timer.sv
// Phase timer for one SRAM halfword transfer.
// Counts while en is high and flags the final cycle of a phase that lasts
// WAIT_CYCLES+1 cycles, then restarts so it can time the next phase.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : a halfword phase is in progress
//   last       : current cycle is the final cycle of the phase
module sram_phase_timer #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic last
);

  logic [3:0] cnt;

  assign last = en && (cnt == 4'(WAIT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller for an asynchronous 16-bit SRAM.
// Each 32-bit LDR/STR is split into a low and a high halfword phase, each
// WAIT_CYCLES+1 cycles long; ready is held low to freeze the pipeline until
// the access completes.
//   clk, rst_n          : clock, synchronous active-low reset
//   mem_r_en, mem_w_en  : load / store request (both set -> store)
//   alu_res, st_val     : byte address and store data from EXE
//   ready               : 1 = MEM stage may advance
//   mem_rdata           : load result to MEM/WB
//   sram_addr, sram_dq  : SRAM halfword address and bidirectional data
//   sram_we_n, sram_oe_n: SRAM strobes, active-low
module sram_mem_ctrl #(
  parameter int unsigned WORD_WIDTH  = sram_mem_ctrl_pkg::WORD_WIDTH,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned ADDR_OFFSET = sram_mem_ctrl_pkg::DEF_ADDR_OFFSET,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [WORD_WIDTH-1:0] alu_res,
  input  logic [WORD_WIDTH-1:0] st_val,
  output logic                  ready,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [SRAM_AW-1:0]    sram_addr,
  inout  logic [15:0]           sram_dq,
  output logic                  sram_we_n,
  output logic                  sram_oe_n
);

  import sram_mem_ctrl_pkg::*;

  mem_state_e            state;
  logic                  is_wr;
  logic [WORD_WIDTH-1:0] st_q;
  logic [15:0]           rdata_lo;
  logic                  req;
  logic                  in_phase;
  logic                  last;
  logic [WORD_WIDTH-1:0] byte_off;
  logic                  unused_off_bits;

  assign req      = mem_r_en | mem_w_en;
  assign in_phase = (state == LO) || (state == HI);

  // The word address is formed at acceptance and kept in sram_addr itself,
  // so only bit 0 has to change between phases.
  assign byte_off        = alu_res - WORD_WIDTH'(ADDR_OFFSET);
  assign unused_off_bits = &{1'b0, byte_off[WORD_WIDTH-1:SRAM_AW+1], byte_off[1:0]};

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (in_phase),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      st_q      <= '0;
      rdata_lo  <= '0;
      mem_rdata <= '0;
      sram_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= LO;
            is_wr     <= mem_w_en;
            st_q      <= st_val;
            sram_addr <= {byte_off[SRAM_AW:2], 1'b0};
          end
        end
        LO: begin
          if (last) begin
            state        <= HI;
            sram_addr[0] <= 1'b1;
            if (!is_wr) rdata_lo <= sram_dq;
          end
        end
        HI: begin
          if (last) begin
            state <= DONE;
            if (!is_wr) mem_rdata <= {sram_dq, rdata_lo};
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == DONE) || ((state == IDLE) && !req);

  // The last cycle of a write phase keeps we_n high so data holds past the strobe.
  assign sram_we_n = !(in_phase && is_wr && !last);
  assign sram_oe_n = !(in_phase && !is_wr);
  assign sram_dq   = (in_phase && is_wr) ? ((state == HI) ? st_q[31:16] : st_q[15:0])
                                         : 'z;

endmodule
